// File: rtl/qn_spi_reader_if.sv
// Byte handshake between the number generator and the SPI read-out buffer.
interface qn_spi_reader_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/qn_spi_reader.sv
// Read-out side of the quantum-number path: a small byte FIFO filled over a
// valid/ready handshake and drained MSB-first through an SPI mode-0 slave.
module qn_spi_reader #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    qn_spi_reader_if.slave           in_bus,
    input  logic                     spi_sclk,
    input  logic                     spi_cs_n,
    output logic                     spi_miso,
    output logic                     spi_miso_oe,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     underflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_n_sync;
    logic                   sclk_prev;
    logic                   cs_n_prev;
    logic                   sclk_fall;
    logic                   cs_fall;
    logic                   cs_rise;

    logic [7:0]             mem [DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count_next;
    logic [7:0]             head;
    logic                   in_ready_q;
    logic                   push;
    logic                   pop;

    // shreg holds the bits still to be sent; the bit on the wire lives in spi_miso
    logic [6:0]             shreg;
    logic [2:0]             bitcnt;

    // Synchronise sclk and cs_n into clk, keeping one extra flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            cs_n_sync <= '1;
            sclk_prev <= 1'b0;
            cs_n_prev <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            cs_n_sync <= {cs_n_sync[SYNC_STAGES-2:0], spi_cs_n};
            sclk_prev <= sclk_sync[SYNC_STAGES-1];
            cs_n_prev <= cs_n_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_fall = sclk_prev & ~sclk_sync[SYNC_STAGES-1];
    assign cs_fall   = cs_n_prev & ~cs_n_sync[SYNC_STAGES-1];
    assign cs_rise   = ~cs_n_prev & cs_n_sync[SYNC_STAGES-1];

    assign in_bus.in_ready = in_ready_q;
    assign push = in_bus.in_valid && in_ready_q;
    assign pop  = (state == LOAD) && !cs_rise && (fifo_count != '0);
    assign head = mem[rd_ptr];

    // Next occupancy, used both for the count and for the registered ready
    always_comb begin
        count_next = fifo_count;
        if (push && !pop) begin
            count_next = fifo_count + CNT_W'(1);
        end else if (pop && !push) begin
            count_next = fifo_count - CNT_W'(1);
        end
    end

    // FIFO pointers, occupancy and registered ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            in_ready_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_count <= count_next;
            in_ready_q <= ena && (count_next < CNT_W'(DEPTH));
        end
    end

    // FIFO storage write port
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_bus.in_data;
    end

    // SPI slave FSM: load a byte on cs assertion and after every 8th sclk fall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            shreg       <= '0;
            bitcnt      <= '0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
            underflow   <= 1'b0;
        end else if (cs_rise) begin
            state       <= IDLE;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    spi_miso <= 1'b0;
                    if (cs_fall) begin
                        state       <= LOAD;
                        spi_miso_oe <= 1'b1;
                    end
                end
                LOAD: begin
                    if (fifo_count != '0) begin
                        spi_miso <= head[7];
                        shreg    <= head[6:0];
                    end else begin
                        spi_miso  <= 1'b0;
                        shreg     <= '0;
                        underflow <= 1'b1;
                    end
                    bitcnt <= '0;
                    state  <= SHIFT;
                end
                SHIFT: begin
                    if (sclk_fall) begin
                        spi_miso <= shreg[6];
                        shreg    <= {shreg[5:0], 1'b0};
                        bitcnt   <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) state <= LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
